// File: rtl/wb_pkg.sv
// Shared types and elaboration helpers for the writeback controller.
package wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        START,
        WAIT_FILT,
        WAIT_ADD,
        FLIP,
        DRAIN,
        GAP
    } wb_state_t;

    // Bits needed to hold values 0..v-1 (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/wb_grp_mux.sv
// Registered row-group to output-port mux with stall hold and sticky errors.
module wb_grp_mux
    import wb_pkg::*;
#(
    parameter int DATA_W    = 25,
    parameter int NUM_ROWS  = 5,
    parameter int NUM_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ROWS*DATA_W-1:0]    row_data,
    input  logic [NUM_ROWS-1:0]           row_valid,
    input  logic                          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic                          err_overflow,
    output logic                          err_pattern
);

    localparam int NUM_GRP = ceil_div(NUM_ROWS, NUM_PORTS);

    logic [NUM_GRP-1:0][NUM_ROWS-1:0]                grp_mask;
    logic [NUM_GRP-1:0][NUM_PORTS-1:0][DATA_W-1:0]   grp_data;
    logic [NUM_GRP-1:0][NUM_PORTS-1:0]               grp_vld;
    logic [NUM_PORTS-1:0][DATA_W-1:0]                sel_data;
    logic [NUM_PORTS-1:0]                            sel_vld;
    logic                                            hit;
    logic                                            stall;

    // Per-group row mask and port-aligned data; the last group may be short,
    // so its trailing ports are tied to zero/invalid.
    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_mask
            assign grp_mask[g][r] = ((r / NUM_PORTS) == g);
        end
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            if (g * NUM_PORTS + p < NUM_ROWS) begin : g_live
                assign grp_data[g][p] = row_data[(g*NUM_PORTS+p)*DATA_W +: DATA_W];
                assign grp_vld[g][p]  = 1'b1;
            end else begin : g_pad
                assign grp_data[g][p] = '0;
                assign grp_vld[g][p]  = 1'b0;
            end
        end
    end

    assign stall = (|out_valid) && !out_ready;

    // Pick the group whose mask matches row_valid exactly, if any.
    always_comb begin
        hit      = 1'b0;
        sel_data = '0;
        sel_vld  = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            if (row_valid == grp_mask[g]) begin
                hit      = 1'b1;
                sel_data = grp_data[g];
                sel_vld  = grp_vld[g];
            end
        end
    end

    // Output beat register; holds while downstream stalls. Errors are sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data     <= '0;
            out_valid    <= '0;
            err_overflow <= 1'b0;
            err_pattern  <= 1'b0;
        end else begin
            if (!stall) begin
                out_data  <= sel_data;
                out_valid <= sel_vld;
            end
            if (stall && hit)             err_overflow <= 1'b1;
            if ((|row_valid) && !hit)     err_pattern  <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_ctrl_grp.sv
// Writeback controller: init/start/flip/drain sequencing plus output mux.
module wb_ctrl_grp
    import wb_pkg::*;
#(
    parameter int DATA_W    = 25,
    parameter int DEPTH     = 46,
    parameter int NUM_ROWS  = 5,
    parameter int NUM_PORTS = 2,
    parameter int START_LEN = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_init,
    input  logic                          p_filter_end,
    input  logic [NUM_ROWS*DATA_W-1:0]    row_data,
    input  logic [NUM_ROWS-1:0]           row_valid,
    input  logic                          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic                          p_init,
    output logic [NUM_ROWS-1:0]           p_write_zero,
    output logic                          start_conv,
    output logic                          odd_cnt,
    output logic                          busy,
    output logic                          err_overflow,
    output logic                          err_pattern
);

    localparam int NUM_GRP = ceil_div(NUM_ROWS, NUM_PORTS);
    localparam int CNT_W   = clog2(DEPTH + START_LEN + 1);
    localparam int GRP_W   = (clog2(NUM_GRP) > 1) ? clog2(NUM_GRP) : 1;

    wb_state_t            state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [GRP_W-1:0]     grp, grp_nxt;
    logic [NUM_ROWS-1:0]  wz_nxt;

    // State, phase counter (cleared on every state change) and drain group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            grp   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            grp   <= grp_nxt;
        end
    end

    // Next-state logic; phase lengths are fixed and ignore backpressure.
    always_comb begin
        state_nxt = state;
        grp_nxt   = grp;
        case (state)
            IDLE:      if (start_init)                   state_nxt = INIT;
            INIT:      if (cnt == CNT_W'(DEPTH - 1))     state_nxt = START;
            START:     if (cnt == CNT_W'(START_LEN - 1)) state_nxt = WAIT_FILT;
            WAIT_FILT: if (p_filter_end)                 state_nxt = WAIT_ADD;
            WAIT_ADD:  if (cnt == CNT_W'(DEPTH - 1))     state_nxt = FLIP;
            FLIP: begin
                state_nxt = DRAIN;
                grp_nxt   = '0;
            end
            DRAIN:     if (cnt == CNT_W'(DEPTH - 1))     state_nxt = GAP;
            GAP: begin
                if (grp == GRP_W'(NUM_GRP - 1)) begin
                    state_nxt = WAIT_FILT;
                end else begin
                    state_nxt = DRAIN;
                    grp_nxt   = grp + GRP_W'(1);
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Rows belonging to the group currently being cleared.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_wz
        assign wz_nxt[r] = (state == DRAIN) && (grp == GRP_W'(r / NUM_PORTS));
    end

    assign busy = (state != IDLE);

    // Control strobes, registered one cycle behind the state that qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_init       <= 1'b0;
            start_conv   <= 1'b0;
            odd_cnt      <= 1'b0;
            p_write_zero <= '0;
        end else begin
            p_init       <= (state == INIT);
            start_conv   <= (state == START) || (state == FLIP);
            odd_cnt      <= odd_cnt ^ (state == FLIP);
            p_write_zero <= wz_nxt;
        end
    end

    wb_grp_mux #(
        .DATA_W    (DATA_W),
        .NUM_ROWS  (NUM_ROWS),
        .NUM_PORTS (NUM_PORTS)
    ) u_mux (
        .clk          (clk),
        .rst          (rst),
        .row_data     (row_data),
        .row_valid    (row_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .err_overflow (err_overflow),
        .err_pattern  (err_pattern)
    );

endmodule

// File: tb/tb_wb_ctrl_grp.sv
// Self-checking bench for wb_ctrl_grp: timeline model for control, beat model for mux.
module tb_wb_ctrl_grp;

    localparam int DW  = 25;
    localparam int DEP = 4;
    localparam int NR  = 5;
    localparam int NP  = 2;
    localparam int SL  = 3;
    localparam int NG  = (NR + NP - 1) / NP;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_init;
    logic                p_filter_end;
    logic [NR*DW-1:0]    row_data;
    logic [NR-1:0]       row_valid;
    logic                out_ready;
    logic [NP*DW-1:0]    out_data;
    logic [NP-1:0]       out_valid;
    logic                p_init;
    logic [NR-1:0]       p_write_zero;
    logic                start_conv;
    logic                odd_cnt;
    logic                busy;
    logic                err_overflow;
    logic                err_pattern;

    int checks   = 0;
    int failures = 0;

    wb_ctrl_grp #(
        .DATA_W(DW), .DEPTH(DEP), .NUM_ROWS(NR), .NUM_PORTS(NP), .START_LEN(SL)
    ) dut (
        .clk(clk), .rst(rst), .start_init(start_init), .p_filter_end(p_filter_end),
        .row_data(row_data), .row_valid(row_valid), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .p_init(p_init),
        .p_write_zero(p_write_zero), .start_conv(start_conv), .odd_cnt(odd_cnt),
        .busy(busy), .err_overflow(err_overflow), .err_pattern(err_pattern)
    );

    always #5 clk = ~clk;

    // Expected control strobes for one output cycle.
    typedef struct packed {
        logic          pi;
        logic          sc;
        logic          fl;
        logic [NR-1:0] wz;
    } ev_t;

    // Mux reference state.
    logic [NP-1:0][DW-1:0] m_data;
    logic [NP-1:0]         m_valid;
    logic                  m_eo, m_ep, m_odd;

    function automatic logic [NR-1:0] mask_of(input int g);
        logic [NR-1:0] m;
        m = '0;
        for (int r = 0; r < NR; r++) m[r] = (r >= g * NP) && (r < g * NP + NP);
        return m;
    endfunction

    function automatic logic [NR*DW-1:0] rand_rows();
        logic [NR*DW-1:0] d;
        for (int r = 0; r < NR; r++) d[r*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_data = '0; m_valid = '0; m_eo = 1'b0; m_ep = 1'b0; m_odd = 1'b0;
    endtask

    // One accepted cycle of the output path, straight from the beat rules.
    task automatic model_step(input logic [NR-1:0] rv, input logic [NR*DW-1:0] rd,
                              input logic rdy);
        logic stall;
        int   hit, r;
        stall = (|m_valid) && !rdy;
        hit = -1;
        for (int g = 0; g < NG; g++) if (rv == mask_of(g)) hit = g;
        if (rv != 0 && hit < 0) m_ep = 1'b1;
        if (stall && hit >= 0)  m_eo = 1'b1;
        if (!stall) begin
            for (int p = 0; p < NP; p++) begin
                r = hit * NP + p;
                if (hit >= 0 && r < NR) begin
                    m_data[p] = rd[r*DW +: DW]; m_valid[p] = 1'b1;
                end else begin
                    m_data[p] = '0; m_valid[p] = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle of row inputs (caller sits at a negedge), land on next negedge.
    task automatic apply(input logic [NR-1:0] rv, input logic [NR*DW-1:0] rd,
                         input logic rdy);
        row_valid = rv; row_data = rd; out_ready = rdy;
        model_step(rv, rd, rdy);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_init = 1'b0; p_filter_end = 1'b0;
        row_data = '0; row_valid = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_data, out_valid, p_init, p_write_zero, start_conv, odd_cnt, busy,
             err_overflow, err_pattern} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h vld=%b pi=%b wz=%b sc=%b odd=%b busy=%b eo=%b ep=%b exp all 0",
                     out_data, out_valid, p_init, p_write_zero, start_conv, odd_cnt, busy,
                     err_overflow, err_pattern);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // start_init (with a simultaneous p_filter_end, which must be ignored).
    task automatic test_init_start();
        ev_t q[$];
        ev_t e;
        e = '0; q.push_back(e);
        e = '0; e.pi = 1'b1; repeat (DEP) q.push_back(e);
        e = '0; e.sc = 1'b1; repeat (SL) q.push_back(e);
        e = '0; repeat (3) q.push_back(e);
        start_init = 1'b1; p_filter_end = 1'b1;
        @(negedge clk);
        start_init = 1'b0; p_filter_end = 1'b0;
        for (int j = 0; j < q.size(); j++) begin
            e = q[j];
            checks++;
            if ({p_init, start_conv, p_write_zero, odd_cnt, busy} !==
                {e.pi, e.sc, e.wz, m_odd, 1'b1}) begin
                failures++;
                $display("FAIL init_seq j=%0d got pi=%b sc=%b wz=%b odd=%b busy=%b exp pi=%b sc=%b wz=%b odd=%b busy=1",
                         j, p_init, start_conv, p_write_zero, odd_cnt, busy,
                         e.pi, e.sc, e.wz, m_odd);
            end
            @(negedge clk);
        end
    endtask

    // One filter pass: wait-add, flip, then one drain per group separated by gaps.
    task automatic test_filter_pass(input logic rdy);
        ev_t q[$];
        ev_t e;
        out_ready = rdy;
        e = '0; repeat (1 + DEP) q.push_back(e);
        e = '0; e.sc = 1'b1; e.fl = 1'b1; q.push_back(e);
        for (int g = 0; g < NG; g++) begin
            e = '0; e.wz = mask_of(g); repeat (DEP) q.push_back(e);
            e = '0; q.push_back(e);
        end
        e = '0; repeat (2) q.push_back(e);
        p_filter_end = 1'b1;
        @(negedge clk);
        p_filter_end = 1'b0;
        for (int j = 0; j < q.size(); j++) begin
            e = q[j];
            if (e.fl) m_odd = ~m_odd;
            checks++;
            if ({p_init, start_conv, p_write_zero, odd_cnt, busy} !==
                {e.pi, e.sc, e.wz, m_odd, 1'b1}) begin
                failures++;
                $display("FAIL pass_seq j=%0d got pi=%b sc=%b wz=%b odd=%b busy=%b exp pi=%b sc=%b wz=%b odd=%b busy=1",
                         j, p_init, start_conv, p_write_zero, odd_cnt, busy,
                         e.pi, e.sc, e.wz, m_odd);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_partial_group();
        logic [NR*DW-1:0] d;
        d = rand_rows();
        d[4*DW +: DW] = 25'h1ABCDE;
        apply(5'b10000, d, 1'b1);
        checks++;
        if (out_valid !== 2'b01 || out_data[0 +: DW] !== 25'h1ABCDE || out_data[DW +: DW] !== '0) begin
            failures++;
            $display("FAIL partial_group got vld=%b p0=%h p1=%h exp vld=01 p0=1abcde p1=0",
                     out_valid, out_data[0 +: DW], out_data[DW +: DW]);
        end
        apply('0, rand_rows(), 1'b1);
        checks++;
        if (out_valid !== 2'b00 || out_data !== '0) begin
            failures++;
            $display("FAIL no_match_zero got vld=%b data=%h exp vld=00 data=0", out_valid, out_data);
        end
    endtask

    task automatic test_stall();
        logic [NR*DW-1:0] d0, d1;
        d0 = rand_rows(); d1 = rand_rows();
        apply(5'b00011, d0, 1'b1);
        repeat (3) begin
            apply('0, rand_rows(), 1'b0);
            checks++;
            if (out_valid !== 2'b11 || out_data !== d0[2*DW-1:0] || err_overflow !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got vld=%b data=%h eo=%b exp vld=11 data=%h eo=0",
                         out_valid, out_data, err_overflow, d0[2*DW-1:0]);
            end
        end
        apply(5'b00011, d1, 1'b0);
        checks++;
        if (out_data !== d0[2*DW-1:0] || err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL stall_overflow got data=%h eo=%b exp data=%h eo=1",
                     out_data, err_overflow, d0[2*DW-1:0]);
        end
        apply(5'b00011, d1, 1'b1);
        checks++;
        if (out_valid !== 2'b11 || out_data !== d1[2*DW-1:0] || err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got vld=%b data=%h eo=%b exp vld=11 data=%h eo=1",
                     out_valid, out_data, err_overflow, d1[2*DW-1:0]);
        end
        apply('0, rand_rows(), 1'b1);
    endtask

    task automatic test_pattern();
        checks++;
        if (err_pattern !== 1'b0) begin
            failures++;
            $display("FAIL pattern_pre got ep=%b exp ep=0", err_pattern);
        end
        apply(5'b00110, rand_rows(), 1'b1);
        checks++;
        if (out_valid !== '0 || out_data !== '0 || err_pattern !== 1'b1) begin
            failures++;
            $display("FAIL pattern_set got vld=%b data=%h ep=%b exp vld=00 data=0 ep=1",
                     out_valid, out_data, err_pattern);
        end
        repeat (3) apply('0, rand_rows(), 1'b1);
        checks++;
        if (err_pattern !== 1'b1) begin
            failures++;
            $display("FAIL pattern_sticky got ep=%b exp ep=1", err_pattern);
        end
    endtask

    // FSM sits in WAIT_FILT on entry; reset lands mid-DRAIN with a held beat.
    task automatic test_rst_mid_drain();
        row_valid = 5'b00011; row_data = rand_rows(); out_ready = 1'b1; p_filter_end = 1'b1;
        @(negedge clk);
        p_filter_end = 1'b0; row_valid = '0; out_ready = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (p_write_zero !== mask_of(0) || out_valid !== 2'b11 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_pre got wz=%b vld=%b busy=%b exp wz=%b vld=11 busy=1",
                     p_write_zero, out_valid, busy, mask_of(0));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_data, out_valid, p_init, p_write_zero, start_conv, odd_cnt, busy,
             err_overflow, err_pattern} !== '0) begin
            failures++;
            $display("FAIL async_reset got vld=%b wz=%b sc=%b odd=%b busy=%b eo=%b ep=%b exp all 0",
                     out_valid, p_write_zero, start_conv, odd_cnt, busy, err_overflow, err_pattern);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        model_reset();
        p_filter_end = 1'b1;
        @(negedge clk);
        p_filter_end = 1'b0;
        for (int j = 0; j < DEP + 4; j++) begin
            checks++;
            if (busy !== 1'b0 || p_write_zero !== '0 || start_conv !== 1'b0 || out_valid !== '0) begin
                failures++;
                $display("FAIL idle_after_rst j=%0d got busy=%b wz=%b sc=%b vld=%b exp 0",
                         j, busy, p_write_zero, start_conv, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] rv;
        logic          rdy;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0, 3:    rv = mask_of(int'($urandom_range(0, NG - 1)));
                1:       rv = NR'($urandom);
                default: rv = '0;
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            apply(rv, rand_rows(), rdy);
            checks++;
            if (out_data !== m_data || out_valid !== m_valid ||
                err_overflow !== m_eo || err_pattern !== m_ep) begin
                failures++;
                $display("FAIL random i=%0d got data=%h vld=%b eo=%b ep=%b exp data=%h vld=%b eo=%b ep=%b",
                         i, out_data, out_valid, err_overflow, err_pattern,
                         m_data, m_valid, m_eo, m_ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_start();
        test_filter_pass(1'b1);
        test_filter_pass(1'b0);
        test_partial_group();
        test_stall();
        test_pattern();
        test_rst_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ctrl_grp.md
Name: wb_ctrl_grp

Overview:
Parametrised writeback controller for the conv kernel. It sequences buffer init, conv start, ping-pong flips and per-row-group zero-clear of the partial-sum buffers. It muxes NUM_ROWS row results onto NUM_PORTS output ports. This generation generalises the fixed 4-row/2-port controller: any row count (including a partial last group), output backpressure, and sticky error flags.

Parameters:
DATA_W, 25, width of one row result
DEPTH, 46, buffer words per row (cycles per init/wait/clear phase); >= 2
NUM_ROWS, 5, row result channels
NUM_PORTS, 2, output ports; 1..NUM_ROWS
START_LEN, 3, cycles start_conv stays high after init
Derived localparams (not overridable): NUM_GRP = ceil(NUM_ROWS/NUM_PORTS); CNT_W = clog2(DEPTH+START_LEN+1); GRP_W = max(1, clog2(NUM_GRP))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_init  in  1  begin buffer init; sampled only in IDLE
p_filter_end  in  1  filter pass finished; sampled only in WAIT_FILT
row_data  in  NUM_ROWS*DATA_W  row r at [r*DATA_W +: DATA_W]
row_valid  in  NUM_ROWS  per-row valid
out_ready  in  1  downstream accepts output beat
out_data  out  NUM_PORTS*DATA_W  port p at [p*DATA_W +: DATA_W]
out_valid  out  NUM_PORTS  per-port valid
p_init  out  1  push zero into empty buffers
p_write_zero  out  NUM_ROWS  clear-after-read strobe per row
start_conv  out  1  conv engine start
odd_cnt  out  1  ping-pong bank select
busy  out  1  FSM not in IDLE
err_overflow  out  1  sticky: new match arrived while output stalled
err_pattern  out  1  sticky: row_valid nonzero and matches no group mask

Behaviour:
- Reset: all outputs 0, FSM IDLE, cnt 0, grp 0. Reset mid-operation takes effect immediately; no pending beat survives. Errors clear only on rst.
- Group g covers rows g*NUM_PORTS .. min(g*NUM_PORTS+NUM_PORTS, NUM_ROWS)-1. MASK[g] is that contiguous bit set.
- FSM states and transitions:
  - IDLE -> INIT on start_init.
  - INIT: DEPTH cycles (cnt 0..DEPTH-1) -> START.
  - START: START_LEN cycles -> WAIT_FILT.
  - WAIT_FILT: -> WAIT_ADD on p_filter_end. No time-out.
  - WAIT_ADD: DEPTH cycles -> FLIP.
  - FLIP: 1 cycle -> DRAIN, grp=0.
  - DRAIN: DEPTH cycles -> GAP.
  - GAP: 1 cycle; if grp==NUM_GRP-1 -> WAIT_FILT, else grp+1 -> DRAIN.
- cnt clears on every state entry and increments otherwise.
- All control outputs are registered, one cycle after the qualifying state cycle:
  - p_init = 1 per INIT cycle.
  - start_conv = 1 per START cycle and for the FLIP cycle.
  - odd_cnt toggles per FLIP cycle.
  - p_write_zero[r] = 1 per DRAIN cycle where r lies in group grp.
  - busy is combinational from the state.
- Output mux, registered, one cycle latency:
  - Stall = |out_valid && !out_ready. During stall, out_data/out_valid hold.
  - When not stalled and row_valid == MASK[g] for some g: group rows go to ports 0.. in order. Ports beyond the group size get data 0, valid 0.
  - When not stalled and no match: all ports data 0, valid 0.
  - err_pattern sets on any cycle with row_valid != 0 matching no MASK.
  - err_overflow sets when stall && row_valid matches a mask; that beat is dropped.
- Control sequencing runs independently of out_ready; backpressure never stretches FSM phases.
- Simultaneous start_init and p_filter_end in IDLE: only start_init acts.

Decomposition:
- Shared package wb_pkg: FSM state enum (IDLE, INIT, START, WAIT_FILT, WAIT_ADD, FLIP, DRAIN, GAP) and a clog2 helper.
- One natural sub-module: wb_grp_mux, the registered row-to-port mux with stall hold and error detection, parametrised by DATA_W, NUM_ROWS, NUM_PORTS.

Test Plan:
- DEPTH=4, START_LEN=3; start_init pulse -> p_init high cycles 2..5, then start_conv high 3 cycles, busy=1, state WAIT_FILT.
- p_filter_end pulse -> after 4 WAIT_ADD cycles, start_conv 1-cycle pulse and odd_cnt 0->1. p_write_zero = 00011 for 4 cycles, gap, 01100 for 4, gap, 10000 for 4, then WAIT_FILT. A second pass flips odd_cnt back to 0.
- NUM_ROWS=5, NUM_PORTS=2, out_ready=1, row_valid=10000, row4=0x1ABCDE -> next cycle out_valid=01, port0=0x1ABCDE, port1=0.
- row_valid=00011 with out_ready=0 held 3 cycles -> output holds row0/row1; a second 00011 during the stall sets err_overflow; releasing out_ready resumes normal output.
- row_valid=00110 -> outputs 0, err_pattern=1 and stays 1 until rst.
- rst asserted mid-DRAIN -> all outputs 0 asynchronously; after release, FSM is in IDLE and ignores p_filter_end.
